// File: rtl/sad_result_collector.sv
// sad_result_collector
//
// Receiving end of the per-core SAD result interface. Accepts one
// (SAD, row, column) result from each of NUM_CORES search cores over a
// valid/ack handshake. Arbitration is round-robin. A single time-shared
// comparator keeps the running minimum. min_valid_o rises once every core
// has reported for the current search.
//
// Optional build macro: SAD_TIE_RASTER_EN
//   defined   : on equal SAD the candidate replaces the incumbent when its
//               {row,col} is lexicographically smaller. The final result
//               does not depend on arrival order.
//   undefined : on equal SAD the earliest-accepted result is kept.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         synchronous, active-high reset
//   start_i       single-cycle pulse that begins a new search (restarts if busy)
//   core_valid_i  per-core result valid, held until acked
//   core_sad_i    packed SADs, core i at [i*SAD_W +: SAD_W]
//   core_row_i    packed rows, core i at [i*IDX_W +: IDX_W]
//   core_col_i    packed columns, core i at [i*IDX_W +: IDX_W]
//   core_ack_o    one-hot, one-cycle accept pulse
//   min_sad_o     running/final minimum SAD
//   min_row_o     row of the minimum
//   min_col_o     column of the minimum
//   min_valid_o   all cores reported, min_* are final
//   busy_o        high while collecting
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for start_i
// COLLECT  | granting one eligible core per cycle, updating the minimum
// DONE     | every core reported; min_* and min_valid_o held

module sad_result_collector #(
    parameter int NUM_CORES = 8,
    parameter int SAD_W     = 32,
    parameter int IDX_W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [NUM_CORES-1:0]       core_valid_i,
    input  logic [NUM_CORES*SAD_W-1:0] core_sad_i,
    input  logic [NUM_CORES*IDX_W-1:0] core_row_i,
    input  logic [NUM_CORES*IDX_W-1:0] core_col_i,
    output logic [NUM_CORES-1:0]       core_ack_o,
    output logic [SAD_W-1:0]           min_sad_o,
    output logic [IDX_W-1:0]           min_row_o,
    output logic [IDX_W-1:0]           min_col_o,
    output logic                       min_valid_o,
    output logic                       busy_o
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CORES-1:0] seen_q, seen_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_CORES-1:0] ack_q, ack_d;
    logic [SAD_W-1:0]     min_sad_q, min_sad_d;
    logic [IDX_W-1:0]     min_row_q, min_row_d;
    logic [IDX_W-1:0]     min_col_q, min_col_d;
    logic                 min_valid_q, min_valid_d;

    logic [NUM_CORES-1:0] eligible;
    logic                 grant_found;
    logic [PTR_W-1:0]     grant_idx;
    int                   scan_idx;

    logic [SAD_W-1:0]     cand_sad;
    logic [IDX_W-1:0]     cand_row;
    logic [IDX_W-1:0]     cand_col;
    logic                 cand_wins;
    logic                 first_accept;

    // Cores that already reported this search are masked out, so a core
    // that keeps its valid high after the ack is simply ignored.
    assign eligible = core_valid_i & ~seen_q;

    // First eligible core at or after the pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NUM_CORES) begin
                scan_idx = scan_idx - NUM_CORES;
            end
            if (!grant_found && eligible[scan_idx[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    assign cand_sad = core_sad_i[grant_idx*SAD_W +: SAD_W];
    assign cand_row = core_row_i[grant_idx*IDX_W +: IDX_W];
    assign cand_col = core_col_i[grant_idx*IDX_W +: IDX_W];

    // The first accept of a search always loads, so an all-ones SAD still
    // brings its own row/col in place of the cleared zeros.
    assign first_accept = (seen_q == '0);

`ifdef SAD_TIE_RASTER_EN
    assign cand_wins = (cand_sad < min_sad_q) ||
                       ((cand_sad == min_sad_q) &&
                        ({cand_row, cand_col} < {min_row_q, min_col_q}));
`else
    assign cand_wins = (cand_sad < min_sad_q);
`endif

    always_comb begin
        state_d     = state_q;
        seen_d      = seen_q;
        ptr_d       = ptr_q;
        ack_d       = '0;
        min_sad_d   = min_sad_q;
        min_row_d   = min_row_q;
        min_col_d   = min_col_q;
        min_valid_d = min_valid_q;

        // Start clears the search from any state; a grant in the same
        // cycle is dropped because the clear takes precedence below.
        if (start_i) begin
            state_d     = ST_COLLECT;
            seen_d      = '0;
            ptr_d       = '0;
            min_sad_d   = '1;
            min_row_d   = '0;
            min_col_d   = '0;
            min_valid_d = 1'b0;
        end else if (state_q == ST_COLLECT && grant_found) begin
            ack_d[grant_idx]  = 1'b1;
            seen_d[grant_idx] = 1'b1;
            if (grant_idx == PTR_W'(NUM_CORES - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
            if (first_accept || cand_wins) begin
                min_sad_d = cand_sad;
                min_row_d = cand_row;
                min_col_d = cand_col;
            end
            if (&seen_d) begin
                state_d     = ST_DONE;
                min_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            seen_q      <= '0;
            ptr_q       <= '0;
            ack_q       <= '0;
            min_sad_q   <= '0;
            min_row_q   <= '0;
            min_col_q   <= '0;
            min_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_q      <= seen_d;
            ptr_q       <= ptr_d;
            ack_q       <= ack_d;
            min_sad_q   <= min_sad_d;
            min_row_q   <= min_row_d;
            min_col_q   <= min_col_d;
            min_valid_q <= min_valid_d;
        end
    end

    assign core_ack_o  = ack_q;
    assign min_sad_o   = min_sad_q;
    assign min_row_o   = min_row_q;
    assign min_col_o   = min_col_q;
    assign min_valid_o = min_valid_q;
    assign busy_o      = (state_q == ST_COLLECT);

endmodule
